// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - UART program loader writing 32-bit words into instruction memory
//
// Boot sequence: send START_BYTE, receive a 4-byte little-endian program size,
// receive the program bytes and write them as 32-bit words into imem, then
// send DONE_BYTE and raise o_boot_done so the core can take over the UART.
//
// Optional feature macro: BOOT_CHECKSUM_EN
//   When defined, a running XOR of the program bytes is kept and one extra
//   checksum byte is received after the data; a mismatch ends in the error state.
//
// Ports:
//   i_clk            system clock
//   i_reset_n        async active-low reset (release synchronised internally)
//   i_rx_rdata       byte from UART_RX
//   i_rx_rdata_ready 1-cycle strobe, i_rx_rdata valid
//   i_rx_ferr        UART_RX framing error
//   o_tx_sdata       byte to UART_TX
//   o_tx_start       1-cycle transmit strobe
//   i_tx_busy        UART_TX busy
//   o_imem_we        imem write strobe
//   o_imem_addr      imem word address
//   o_imem_wdata     imem write data
//   o_boot_done      program loaded, UART handed to the core
//   o_boot_err       sticky load error
module uart_boot_loader #(
    parameter int         IMEM_ADDR_W = 15,
    parameter logic [7:0] START_BYTE  = 8'h99,
    parameter logic [7:0] DONE_BYTE   = 8'hAA
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic [7:0]             i_rx_rdata,
    input  logic                   i_rx_rdata_ready,
    input  logic                   i_rx_ferr,
    output logic [7:0]             o_tx_sdata,
    output logic                   o_tx_start,
    input  logic                   i_tx_busy,
    output logic                   o_imem_we,
    output logic [IMEM_ADDR_W-1:0] o_imem_addr,
    output logic [31:0]            o_imem_wdata,
    output logic                   o_boot_done,
    output logic                   o_boot_err
);

`ifdef BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {S_REQ, S_SIZE, S_DATA, S_CSUM, S_FIN, S_DONE, S_ERR} state_t;
    localparam state_t S_POST = S_CSUM;
`else
    typedef enum logic [2:0] {S_REQ, S_SIZE, S_DATA, S_FIN, S_DONE, S_ERR} state_t;
    localparam state_t S_POST = S_FIN;
`endif

    // Largest accepted program, in bytes.
    localparam logic [32:0] CAP_BYTES = 33'd4 << IMEM_ADDR_W;

    logic [1:0]             r_rst_sync;
    logic                   w_rst_n;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [31:0]            r_byte_cnt;
    logic [31:0]            w_byte_cnt_inc;
    logic [1:0]             w_k;
    logic [31:0]            r_size;
    logic [31:0]            w_size_full;
    logic                   w_size_bad;
    logic [31:0]            r_word;
    logic                   r_guard;
    logic                   w_send_ok;
    logic                   w_tx_fire;
    logic [7:0]             w_tx_byte;
    logic                   w_rx_ok;
    logic [7:0]             r_tx_sdata;
    logic                   r_tx_start;
    logic                   r_imem_we;
    logic [IMEM_ADDR_W-1:0] r_imem_addr;
    logic [31:0]            r_imem_wdata;
    logic                   r_boot_done;
    logic                   r_boot_err;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]             r_csum;
`endif

    // Reset asserts immediately and releases on a clock edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_byte_cnt_inc = r_byte_cnt + 32'd1;
    assign w_k            = r_byte_cnt[1:0];
    assign w_size_full    = {i_rx_rdata, r_size[23:0]};
    assign w_size_bad     = (w_size_full[1:0] != 2'b00) || ({1'b0, w_size_full} > CAP_BYTES);
    assign w_rx_ok        = i_rx_rdata_ready && !i_rx_ferr;
    // The guard and the pulse itself block a fire while tx_busy has not yet risen.
    assign w_send_ok      = !i_tx_busy && !r_guard && !r_tx_start;

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tx_fire   = 1'b0;
        w_tx_byte   = START_BYTE;
        case (r_state)
            S_REQ: begin
                w_tx_fire = w_send_ok;
                if (r_tx_start) begin
                    w_state_nxt = S_SIZE;
                end
            end
            S_SIZE: begin
                if (i_rx_ferr) begin
                    w_state_nxt = S_ERR;
                end else if (i_rx_rdata_ready && (w_k == 2'd3)) begin
                    if (w_size_bad) begin
                        w_state_nxt = S_ERR;
                    end else if (w_size_full == 32'd0) begin
                        w_state_nxt = S_POST;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (i_rx_ferr) begin
                    w_state_nxt = S_ERR;
                end else if (i_rx_rdata_ready && (w_byte_cnt_inc == r_size)) begin
                    w_state_nxt = S_POST;
                end
            end
`ifdef BOOT_CHECKSUM_EN
            S_CSUM: begin
                if (i_rx_ferr) begin
                    w_state_nxt = S_ERR;
                end else if (i_rx_rdata_ready) begin
                    w_state_nxt = (i_rx_rdata == r_csum) ? S_FIN : S_ERR;
                end
            end
`endif
            S_FIN: begin
                w_tx_byte = DONE_BYTE;
                w_tx_fire = w_send_ok;
                if (r_tx_start) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_byte_cnt   <= 32'd0;
            r_size       <= 32'd0;
            r_word       <= 32'd0;
            r_guard      <= 1'b0;
            r_tx_sdata   <= 8'd0;
            r_tx_start   <= 1'b0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= 32'd0;
            r_boot_done  <= 1'b0;
            r_boot_err   <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            r_csum       <= 8'd0;
`endif
        end else begin
            r_tx_start  <= w_tx_fire;
            r_guard     <= r_tx_start;
            r_imem_we   <= 1'b0;
            r_boot_done <= (w_state_nxt == S_DONE);
            r_boot_err  <= (w_state_nxt == S_ERR);
            if (w_tx_fire) begin
                r_tx_sdata <= w_tx_byte;
            end
            if (r_state == S_SIZE && w_rx_ok) begin
                r_size[{w_k, 3'b000} +: 8] <= i_rx_rdata;
                // Restart the count so the data phase counts program bytes only.
                r_byte_cnt <= (w_k == 2'd3) ? 32'd0 : w_byte_cnt_inc;
            end
            if (r_state == S_DATA && w_rx_ok) begin
                r_word[{w_k, 3'b000} +: 8] <= i_rx_rdata;
                r_byte_cnt <= w_byte_cnt_inc;
`ifdef BOOT_CHECKSUM_EN
                r_csum <= r_csum ^ i_rx_rdata;
`endif
                if (w_k == 2'd3) begin
                    r_imem_we    <= 1'b1;
                    r_imem_addr  <= r_byte_cnt[IMEM_ADDR_W+1:2];
                    r_imem_wdata <= {i_rx_rdata, r_word[23:0]};
                end
            end
        end
    end

    assign o_tx_sdata   = r_tx_sdata;
    assign o_tx_start   = r_tx_start;
    assign o_imem_we    = r_imem_we;
    assign o_imem_addr  = r_imem_addr;
    assign o_imem_wdata = r_imem_wdata;
    assign o_boot_done  = r_boot_done;
    assign o_boot_err   = r_boot_err;

endmodule
